tb_mbox_monitor: RTL

Parametrised, synthesizable pass/fail mailbox monitor for core-level benches and FPGA smoke tests.
- Snoops NUM_CH fabric write ports; one per core or hart under test.
- Each channel watches its own 32-bit mailbox word and reports PASS, FAIL or TIMEOUT.
- Adds what polling benches lack: multi-channel operation, a per-channel heartbeat watchdog, byte-strobe merging, terminal-state protection and a global done/pass summary.

---
 rtl/tb_status_pkg.sv | 25 ++
 rtl/tb_mbox_channel.sv | 60 ++++++
 rtl/tb_mbox_monitor.sv | 81 ++++++++
 3 files changed

// File: rtl/tb_status_pkg.sv
// Shared types and helpers for the mailbox pass/fail monitor.
package tb_status_pkg;

  typedef enum logic [1:0] {
    ST_RUNNING = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } ch_state_e;

  localparam logic [31:0] DEF_PASS_WORD = 32'h0000_0ACE;
  localparam logic [31:0] DEF_FAIL_WORD = 32'h0000_0BAD;

  // Overlay the strobed bytes of wdata onto the current shadow word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] shadow,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = shadow;
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/tb_mbox_channel.sv
// One monitored channel: mailbox shadow, heartbeat watchdog and verdict FSM.
import tb_status_pkg::*;

module tb_mbox_channel #(
  parameter logic [31:0] PASS_WORD      = DEF_PASS_WORD,
  parameter logic [31:0] FAIL_WORD      = DEF_FAIL_WORD,
  parameter int          TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        hit,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [1:0]  state,
  output logic [31:0] word,
  output logic        proto_err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  ch_state_e       st;
  logic [WD_W-1:0] wd;
  logic [31:0]     merged;

  // merged is only consumed when hit is high, so X on idle data is harmless
  assign merged = merge_bytes(word, wdata, wstrb);
  assign state  = st;

  // Verdict FSM; a hit always beats a same-cycle watchdog expiry
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      st        <= ST_RUNNING;
      wd        <= '0;
      word      <= '0;
      proto_err <= 1'b0;
    end else begin
      case (st)
        ST_RUNNING: begin
          if (hit) begin
            word <= merged;
            wd   <= '0;
            if (merged == PASS_WORD)      st <= ST_PASS;
            else if (merged == FAIL_WORD) st <= ST_FAIL;
          end else if (wd == WD_LAST) begin
            st <= ST_TIMEOUT;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
          // terminal: everything frozen, late mailbox writes are flagged
          if (hit) proto_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/tb_mbox_monitor.sv
// Multi-channel mailbox monitor: per-channel address decode, channel array,
// global done/pass summary and an elapsed-cycle counter.
import tb_status_pkg::*;

module tb_mbox_monitor #(
  parameter int                NUM_CH         = 4,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] MBOX_BASE      = ADDR_W'(32'h0000_0044),
  parameter logic [31:0]       PASS_WORD      = DEF_PASS_WORD,
  parameter logic [31:0]       FAIL_WORD      = DEF_FAIL_WORD,
  parameter int                TIMEOUT_CYCLES = 2000,
  parameter int                CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        snoop_valid,
  input  logic [NUM_CH-1:0]        snoop_ready,
  input  logic [NUM_CH*ADDR_W-1:0] snoop_addr,
  input  logic [NUM_CH*32-1:0]     snoop_wdata,
  input  logic [NUM_CH*4-1:0]      snoop_wstrb,
  output logic [NUM_CH*2-1:0]      ch_state,
  output logic [NUM_CH*32-1:0]     ch_word,
  output logic [NUM_CH-1:0]        proto_err,
  output logic                     done,
  output logic                     all_pass,
  output logic                     any_fail,
  output logic [CNT_W-1:0]         cycles_elapsed
);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] is_term;
  logic [NUM_CH-1:0] is_pass;
  logic [NUM_CH-1:0] is_bad;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] CH_ADDR = MBOX_BASE + ADDR_W'(4 * c);

    // byte offset within the mailbox word does not matter
    logic unused_lo;
    assign unused_lo = ^snoop_addr[c*ADDR_W +: 2];

    // handshake gates the compare so idle X on the bus never reaches state
    assign hit[c] = snoop_valid[c] & snoop_ready[c] &
                    (snoop_addr[c*ADDR_W+2 +: ADDR_W-2] == CH_ADDR[ADDR_W-1:2]);

    tb_mbox_channel #(
      .PASS_WORD      (PASS_WORD),
      .FAIL_WORD      (FAIL_WORD),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .hit       (hit[c]),
      .wdata     (snoop_wdata[c*32 +: 32]),
      .wstrb     (snoop_wstrb[c*4 +: 4]),
      .state     (ch_state[c*2 +: 2]),
      .word      (ch_word[c*32 +: 32]),
      .proto_err (proto_err[c])
    );

    assign is_term[c] = (ch_state[c*2 +: 2] != ST_RUNNING);
    assign is_pass[c] = (ch_state[c*2 +: 2] == ST_PASS);
    assign is_bad[c]  = (ch_state[c*2 +: 2] == ST_FAIL) ||
                        (ch_state[c*2 +: 2] == ST_TIMEOUT);
  end

  assign done     = &is_term;
  assign all_pass = done & (&is_pass);
  assign any_fail = |is_bad;

  // Run-time counter: stops once every channel has a verdict, never wraps
  always_ff @(posedge clk) begin
    if (rst || clear)
      cycles_elapsed <= '0;
    else if (!done && (cycles_elapsed != {CNT_W{1'b1}}))
      cycles_elapsed <= cycles_elapsed + CNT_W'(1);
  end

endmodule
